// File: rtl/dzcpu_ucode_pkg.sv
// Shared encodings for the DZCPU micro-op sequencer: uop flow field values
// and sequencer FSM state codes.
package dzcpu_ucode_pkg;

    localparam logic [2:0] FLOW_OP        = 3'd0;
    localparam logic [2:0] FLOW_INC       = 3'd1;
    localparam logic [2:0] FLOW_EOF       = 3'd2;
    localparam logic [2:0] FLOW_INC_EOF   = 3'd3;
    localparam logic [2:0] FLOW_INC_EOF_Z = 3'd4;
    localparam logic [2:0] FLOW_JCB       = 3'd5;
    localparam logic [2:0] FLOW_CALL      = 3'd6;
    localparam logic [2:0] FLOW_RET       = 3'd7;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_CBWAIT = 2'd1;
    localparam logic [1:0] ST_LOOKUP = 2'd2;
    localparam logic [1:0] ST_RUN    = 2'd3;

    // Opcode intake is open only while waiting for a base or CB opcode byte.
    function automatic logic mop_ready(input logic [1:0] st);
        return (st == ST_IDLE) || (st == ST_CBWAIT);
    endfunction

endpackage

// File: rtl/dzcpu_ucode_stack.sv
// Return-address stack for uop CALL/RET; push/pop are ignored when full/empty,
// clear empties it in one cycle.
module dzcpu_ucode_stack
    import dzcpu_ucode_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int STACK_D = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic              full,
    output logic              empty
);

    localparam int CNT_W = $clog2(STACK_D + 1);

    logic [CNT_W-1:0]  cnt_r;
    logic [ADDR_W-1:0] mem_r [STACK_D];
    logic [ADDR_W-1:0] top_s;

    assign full  = (cnt_r == CNT_W'(STACK_D));
    assign empty = (cnt_r == {CNT_W{1'b0}});
    assign top   = top_s;

    // Occupancy counter.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (push && !full) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else if (pop && !empty) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Entry storage; slot i is written when the count equals i.
    always_ff @(posedge clk) begin
        for (int i = 0; i < STACK_D; i++) begin
            if (rst) begin
                mem_r[i] <= {ADDR_W{1'b0}};
            end else if (push && !full && !clear && (cnt_r == CNT_W'(i))) begin
                mem_r[i] <= push_data;
            end else begin
                mem_r[i] <= mem_r[i];
            end
        end
    end

    // Top-of-stack select.
    always_comb begin
        top_s = {ADDR_W{1'b0}};
        for (int i = 0; i < STACK_D; i++) begin
            if (cnt_r == CNT_W'(i + 1)) begin
                top_s = mem_r[i];
            end else begin
                top_s = top_s;
            end
        end
    end

endmodule

// File: rtl/dzcpu_ucode_seq.sv
// DZCPU micro-op sequencer: opcode intake, flow LUT lookup and uPC stepping.
// Define DZCPU_UCODE_SEQ_COND_EOF_EN to make INC_EOF_Z end the flow on Z=1.
module dzcpu_ucode_seq
    import dzcpu_ucode_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int UOP_W   = 12,
    parameter int STACK_D = 2
) (
    input  logic              iClock,
    input  logic              iReset,
    input  logic [7:0]        iMop,
    input  logic              iMopValid,
    output logic              oMopReady,
    output logic [7:0]        oLutMop,
    output logic              oLutPage,
    input  logic [ADDR_W-1:0] iFlowIdx,
    output logic [ADDR_W-1:0] oUopAddr,
    input  logic [UOP_W-1:0]  iUop,
    output logic              oUopValid,
    input  logic              iStall,
    input  logic              iZFlag,
    output logic              oPcInc,
    output logic              oEof,
    output logic              oStackErr
);

    localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [1:0]        state_r, state_nxt_s;
    logic [ADDR_W-1:0] upc_r, upc_nxt_s, upc_inc_s;
    logic [7:0]        lut_mop_r;
    logic              lut_page_r, page_nxt_s;
    logic              err_r;
    logic              mop_load_s, pc_inc_s, eof_s, push_s, pop_s, err_set_s;
    logic [2:0]        flow_s;
    logic [ADDR_W-1:0] operand_s, stack_top_s;
    logic              stack_full_s, stack_empty_s;
    logic              unused_s;

    assign flow_s    = iUop[UOP_W-1 -: 3];
    assign operand_s = iUop[ADDR_W-1:0];
    assign upc_inc_s = upc_r + ONE;

`ifdef DZCPU_UCODE_SEQ_COND_EOF_EN
    assign unused_s = ^iUop;
`else
    assign unused_s = ^{iUop, iZFlag};
`endif

    dzcpu_ucode_stack #(
        .ADDR_W  (ADDR_W),
        .STACK_D (STACK_D)
    ) u_stack (
        .clk       (iClock),
        .rst       (iReset),
        .clear     (eof_s),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (upc_inc_s),
        .top       (stack_top_s),
        .full      (stack_full_s),
        .empty     (stack_empty_s)
    );

    // Next-state, uPC and pulse decode.
    always_comb begin
        state_nxt_s = state_r;
        upc_nxt_s   = upc_r;
        page_nxt_s  = lut_page_r;
        mop_load_s  = 1'b0;
        pc_inc_s    = 1'b0;
        eof_s       = 1'b0;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        err_set_s   = 1'b0;
        case (state_r)
            ST_IDLE, ST_CBWAIT: begin
                if (iMopValid) begin
                    mop_load_s  = 1'b1;
                    page_nxt_s  = (state_r == ST_CBWAIT);
                    state_nxt_s = ST_LOOKUP;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            ST_LOOKUP: begin
                upc_nxt_s   = iFlowIdx;
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                if (iStall) begin
                    state_nxt_s = state_r;
                end else begin
                    case (flow_s)
                        FLOW_OP: upc_nxt_s = upc_inc_s;
                        FLOW_INC: begin
                            pc_inc_s  = 1'b1;
                            upc_nxt_s = upc_inc_s;
                        end
                        FLOW_EOF: begin
                            eof_s       = 1'b1;
                            state_nxt_s = ST_IDLE;
                        end
                        FLOW_INC_EOF: begin
                            pc_inc_s    = 1'b1;
                            eof_s       = 1'b1;
                            state_nxt_s = ST_IDLE;
                        end
                        FLOW_INC_EOF_Z: begin
                            pc_inc_s = 1'b1;
`ifdef DZCPU_UCODE_SEQ_COND_EOF_EN
                            if (iZFlag) begin
                                eof_s       = 1'b1;
                                state_nxt_s = ST_IDLE;
                            end else begin
                                upc_nxt_s = upc_inc_s;
                            end
`else
                            upc_nxt_s = upc_inc_s;
`endif
                        end
                        FLOW_JCB: state_nxt_s = ST_CBWAIT;
                        FLOW_CALL: begin
                            if (stack_full_s) begin
                                err_set_s   = 1'b1;
                                eof_s       = 1'b1;
                                state_nxt_s = ST_IDLE;
                            end else begin
                                push_s    = 1'b1;
                                upc_nxt_s = operand_s;
                            end
                        end
                        FLOW_RET: begin
                            if (stack_empty_s) begin
                                err_set_s   = 1'b1;
                                eof_s       = 1'b1;
                                state_nxt_s = ST_IDLE;
                            end else begin
                                pop_s     = 1'b1;
                                upc_nxt_s = stack_top_s;
                            end
                        end
                        default: begin
                            eof_s       = 1'b1;
                            state_nxt_s = ST_IDLE;
                        end
                    endcase
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Sequencer state registers.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_r    <= ST_IDLE;
            upc_r      <= {ADDR_W{1'b0}};
            lut_mop_r  <= 8'h00;
            lut_page_r <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            upc_r      <= upc_nxt_s;
            lut_page_r <= page_nxt_s;
            lut_mop_r  <= mop_load_s ? iMop : lut_mop_r;
            err_r      <= err_r | err_set_s;
        end
    end

    assign oMopReady = mop_ready(state_r);
    assign oLutMop   = lut_mop_r;
    assign oLutPage  = lut_page_r;
    assign oUopAddr  = upc_r;
    assign oStackErr = err_r;
    assign oUopValid = (state_r == ST_RUN) & ~iReset;
    assign oPcInc    = pc_inc_s & ~iReset;
    assign oEof      = eof_s & ~iReset;

endmodule

// File: tb/tb_dzcpu_ucode_seq.sv
// Scoreboard bench for dzcpu_ucode_seq: stimulus queues expected uop records,
// a negedge monitor pops one per executed uop.
module tb_dzcpu_ucode_seq;
    import dzcpu_ucode_pkg::*;

    logic        iClock = 1'b0;
    logic        iReset, iMopValid, iStall, iZFlag;
    logic [7:0]  iMop;
    logic        oMopReady, oLutPage, oUopValid, oPcInc, oEof, oStackErr;
    logic [7:0]  oLutMop, iFlowIdx, oUopAddr;
    logic [11:0] iUop;

    logic [7:0]  base_lut [256];
    logic [7:0]  cb_lut   [256];
    logic [11:0] rom      [256];

    typedef struct packed {
        logic [7:0] upc;
        logic       inc;
        logic       eof;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    always #5 iClock = ~iClock;

    assign iFlowIdx = oLutPage ? cb_lut[oLutMop] : base_lut[oLutMop];
    assign iUop     = rom[oUopAddr];

    dzcpu_ucode_seq #(.ADDR_W(8), .UOP_W(12), .STACK_D(2)) dut (
        .iClock    (iClock),
        .iReset    (iReset),
        .iMop      (iMop),
        .iMopValid (iMopValid),
        .oMopReady (oMopReady),
        .oLutMop   (oLutMop),
        .oLutPage  (oLutPage),
        .iFlowIdx  (iFlowIdx),
        .oUopAddr  (oUopAddr),
        .iUop      (iUop),
        .oUopValid (oUopValid),
        .iStall    (iStall),
        .iZFlag    (iZFlag),
        .oPcInc    (oPcInc),
        .oEof      (oEof),
        .oStackErr (oStackErr)
    );

    function automatic logic [11:0] mk(input logic [2:0] f, input logic [7:0] op);
        return {f, 1'b0, op};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic ex(input logic [7:0] upc, input logic inc, input logic eof);
        exp_t e;
        e.upc = upc;
        e.inc = inc;
        e.eof = eof;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge iClock);
        #1;
    endtask

    task automatic issue(input logic [7:0] m);
        int n = 0;
        while (oMopReady !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        chk("ready_before_issue", 32'(oMopReady), 32'd1);
        iMop      = m;
        iMopValid = 1'b1;
        tick();
        iMopValid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (oMopReady !== 1'b1 && n < 64) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(oMopReady), 32'd1);
    endtask

    // Monitor: every executed uop must match the next queued expectation.
    always @(negedge iClock) begin
        if (oUopValid === 1'b1) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_uop: got upc %0h expected none", oUopAddr);
            end else begin
                mon_e = q.pop_front();
                chk("uop_addr", 32'(oUopAddr), 32'(mon_e.upc));
                chk("pc_inc",   32'(oPcInc),   32'(mon_e.inc));
                chk("eof",      32'(oEof),     32'(mon_e.eof));
            end
        end else begin
            chk("pulses_outside_run", 32'({oPcInc, oEof}), 32'd0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            base_lut[i] = 8'hF0;
            cb_lut[i]   = 8'hF0;
            rom[i]      = mk(FLOW_EOF, 8'h00);
        end
        base_lut[8'h31] = 8'h01;
        base_lut[8'h40] = 8'h08;
        base_lut[8'hCB] = 8'h0C;
        base_lut[8'h7C] = 8'h1E;
        base_lut[8'h50] = 8'h05;
        base_lut[8'h60] = 8'h60;
        base_lut[8'h70] = 8'h70;
        base_lut[8'h80] = 8'hFF;
        cb_lut[8'h7C]   = 8'h10;
        rom[8'h01] = mk(FLOW_INC, 8'h00);
        rom[8'h02] = mk(FLOW_INC, 8'h00);
        rom[8'h03] = mk(FLOW_OP, 8'h00);
        rom[8'h04] = mk(FLOW_INC_EOF, 8'h00);
        rom[8'h05] = mk(FLOW_CALL, 8'h20);
        rom[8'h20] = mk(FLOW_RET, 8'h00);
        rom[8'h06] = mk(FLOW_CALL, 8'h30);
        rom[8'h30] = mk(FLOW_CALL, 8'h40);
        rom[8'h40] = mk(FLOW_CALL, 8'h50);
        rom[8'h08] = mk(FLOW_INC_EOF_Z, 8'h00);
        rom[8'h09] = mk(FLOW_EOF, 8'h00);
        rom[8'h0C] = mk(FLOW_JCB, 8'h00);
        rom[8'h10] = mk(FLOW_INC_EOF, 8'h00);
        rom[8'h60] = mk(FLOW_RET, 8'h00);
        rom[8'h70] = mk(FLOW_OP, 8'h00);
        rom[8'h71] = mk(FLOW_OP, 8'h00);
        rom[8'h72] = mk(FLOW_INC_EOF, 8'h00);
        rom[8'hFF] = mk(FLOW_INC, 8'h00);
        rom[8'h00] = mk(FLOW_INC_EOF, 8'h00);

        iReset = 1'b1; iMopValid = 1'b0; iStall = 1'b0; iZFlag = 1'b0; iMop = 8'h00;
        tick();
        tick();
        chk("reset_uop_valid", 32'(oUopValid), 32'd0);
        iReset = 1'b0;
        chk("reset_ready",    32'(oMopReady), 32'd1);
        chk("reset_upc",      32'(oUopAddr),  32'd0);
        chk("reset_lut_mop",  32'(oLutMop),   32'd0);
        chk("reset_lut_page", 32'(oLutPage),  32'd0);
        chk("reset_err",      32'(oStackErr), 32'd0);

        // Basic flow: uPC 1..4 on cycles 2..5, ready again on cycle 6.
        ex(8'h01, 1'b1, 1'b0); ex(8'h02, 1'b1, 1'b0);
        ex(8'h03, 1'b0, 1'b0); ex(8'h04, 1'b1, 1'b1);
        issue(8'h31);
        chk("lookup_not_ready", 32'(oMopReady), 32'd0);
        chk("lookup_lut_mop",   32'(oLutMop),   32'h31);
        chk("lookup_page",      32'(oLutPage),  32'd0);
        repeat (4) tick();
        chk("cycle5_not_ready", 32'(oMopReady), 32'd0);
        tick();
        chk("cycle6_ready", 32'(oMopReady), 32'd1);

        // Stall three cycles at uPC 2.
        ex(8'h01, 1'b1, 1'b0);
        ex(8'h02, 1'b0, 1'b0); ex(8'h02, 1'b0, 1'b0); ex(8'h02, 1'b0, 1'b0);
        ex(8'h02, 1'b1, 1'b0); ex(8'h03, 1'b0, 1'b0); ex(8'h04, 1'b1, 1'b1);
        issue(8'h31);
        tick();
        tick();
        iStall = 1'b1;
        repeat (3) tick();
        iStall = 1'b0;
        wait_idle();

        // INC_EOF_Z with Z=1 then Z=0.
        iZFlag = 1'b1;
`ifdef DZCPU_UCODE_SEQ_COND_EOF_EN
        ex(8'h08, 1'b1, 1'b1);
`else
        ex(8'h08, 1'b1, 1'b0); ex(8'h09, 1'b0, 1'b1);
`endif
        issue(8'h40);
        wait_idle();
        iZFlag = 1'b0;
        ex(8'h08, 1'b1, 1'b0); ex(8'h09, 1'b0, 1'b1);
        issue(8'h40);
        wait_idle();

        // CB page: JCB, then 0x7C selects CB LUT entry 16.
        ex(8'h0C, 1'b0, 1'b0);
        issue(8'hCB);
        tick();
        tick();
        chk("cbwait_ready", 32'(oMopReady), 32'd1);
        chk("cbwait_page_not_set", 32'(oLutPage), 32'd0);
        ex(8'h10, 1'b1, 1'b1);
        issue(8'h7C);
        chk("cb_page",    32'(oLutPage), 32'd1);
        chk("cb_lut_mop", 32'(oLutMop),  32'h7C);
        tick();
        chk("cb_upc", 32'(oUopAddr), 32'h10);
        wait_idle();

        // uPC wraps from 0xFF to 0x00.
        ex(8'hFF, 1'b1, 1'b0); ex(8'h00, 1'b1, 1'b1);
        issue(8'h80);
        wait_idle();

        // CALL/RET, then overflow on the third nested CALL.
        ex(8'h05, 1'b0, 1'b0); ex(8'h20, 1'b0, 1'b0); ex(8'h06, 1'b0, 1'b0);
        ex(8'h30, 1'b0, 1'b0); ex(8'h40, 1'b0, 1'b1);
        issue(8'h50);
        wait_idle();
        chk("overflow_err", 32'(oStackErr), 32'd1);

        // Reset mid-flow while stalled.
        ex(8'h70, 1'b0, 1'b0); ex(8'h71, 1'b0, 1'b0);
        issue(8'h70);
        tick();
        tick();
        tick();
        iReset = 1'b1;
        iStall = 1'b1;
        tick();
        iReset = 1'b0;
        iStall = 1'b0;
        chk("midreset_ready",    32'(oMopReady), 32'd1);
        chk("midreset_upc",      32'(oUopAddr),  32'd0);
        chk("midreset_err",      32'(oStackErr), 32'd0);
        chk("midreset_lut_mop",  32'(oLutMop),   32'd0);
        chk("midreset_valid",    32'(oUopValid), 32'd0);

        // RET on empty stack.
        ex(8'h60, 1'b0, 1'b1);
        issue(8'h60);
        wait_idle();
        chk("underflow_err", 32'(oStackErr), 32'd1);

        repeat (3) tick();
        chk("queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dzcpu_ucode_seq.md
DZCPU_UCODE_SEQ -- requirements
Module: dzcpu_ucode_seq

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: micro-op (uop) address width.
REQ-002 SHALL have parameter UOP_W, default 12: uop word width; bits [UOP_W-1:UOP_W-3] = flow field, bits [ADDR_W-1:0] = operand; UOP_W-3 >= ADDR_W is required.
REQ-003 SHALL have parameter STACK_D, default 2: depth of the uop return stack.
REQ-004 SHALL have port iClock  in  1  the one clock; all state updates on its rising edge.
REQ-005 SHALL have port iReset  in  1  reset, synchronous and active-high.
REQ-006 SHALL have port iMop  in  8  opcode byte (base opcode, or CB second byte).
REQ-007 SHALL have port iMopValid  in  1  iMop valid.
REQ-008 SHALL have port oMopReady  out  1  sequencer can accept iMop.
REQ-009 SHALL have port oLutMop  out  8  latched opcode driven to the flow LUTs.
REQ-010 SHALL have port oLutPage  out  1  LUT select: 0 = base page, 1 = CB page.
REQ-011 SHALL have port iFlowIdx  in  ADDR_W  flow start index returned combinationally by the selected LUT.
REQ-012 SHALL have port oUopAddr  out  ADDR_W  uop ROM address (uPC).
REQ-013 SHALL have port iUop  in  UOP_W  uop ROM data for oUopAddr, combinational.
REQ-014 SHALL have port oUopValid  out  1  iUop is being executed this cycle.
REQ-015 SHALL have ports iStall (in, 1, datapath/memory busy) and iZFlag (in, 1, Z flag).
REQ-016 SHALL have ports oPcInc (out, 1, one-cycle program-counter increment pulse) and oEof (out, 1, end-of-flow pulse).
REQ-017 SHALL have port oStackErr  out  1  sticky return-stack overflow/underflow flag.

Function
REQ-018 SHALL implement states IDLE, CBWAIT, LOOKUP and RUN.
REQ-019 IDLE and CBWAIT SHALL assert oMopReady=1; all other states SHALL drive oMopReady=0.
REQ-020 In IDLE, on iMopValid&oMopReady, the block SHALL latch oLutMop=iMop, set oLutPage=0 and go to LOOKUP.
REQ-021 In CBWAIT, on accept, the block SHALL latch oLutMop=iMop, set oLutPage=1 and go to LOOKUP.
REQ-022 LOOKUP SHALL last exactly one cycle: uPC<=iFlowIdx, then go to RUN; this gives a first uop 2 cycles after opcode accept.
REQ-023 RUN SHALL assert oUopValid=1; while iStall=1, uPC, stack and state SHALL hold and oPcInc=oEof=0.
REQ-024 In RUN with iStall=0, flow OP SHALL set uPC<=uPC+1.
REQ-025 Flow INC SHALL set uPC<=uPC+1 and pulse oPcInc.
REQ-026 Flow EOF SHALL pulse oEof and go to IDLE.
REQ-027 Flow INC_EOF SHALL pulse oPcInc and oEof and go to IDLE.
REQ-028 Flow INC_EOF_Z SHALL pulse oPcInc; if iZFlag=1 it SHALL also pulse oEof and go to IDLE, otherwise it SHALL set uPC<=uPC+1.
REQ-029 Flow JCB SHALL go to CBWAIT; uPC is don't-care until LOOKUP.
REQ-030 Flow CALL SHALL push uPC+1 and set uPC<=operand; if the stack is full, it SHALL instead set oStackErr, pulse oEof and go to IDLE.
REQ-031 Flow RET SHALL pop into uPC; if the stack is empty, it SHALL instead set oStackErr, pulse oEof and go to IDLE.
REQ-032 uPC arithmetic SHALL be modulo 2^ADDR_W (all-ones+1 wraps to 0).
REQ-033 On EOF the stack SHALL be cleared.
REQ-034 oPcInc and oEof SHALL be combinational from state, iUop, iStall and iZFlag, asserted only in RUN.
REQ-035 iMopValid outside IDLE/CBWAIT SHALL be ignored; the source holds it.

Reset
REQ-036 When iReset=1 at a clock edge, the block SHALL enter IDLE with uPC=0, oLutMop=0, oLutPage=0, stack empty and oStackErr=0; this SHALL hold from any state, including mid-flow and under iStall.
REQ-037 During reset, oUopValid, oPcInc and oEof SHALL be 0.

Configuration
REQ-038 SHALL support macro DZCPU_UCODE_SEQ_COND_EOF_EN; when defined, INC_EOF_Z SHALL behave per REQ-028.
REQ-039 When DZCPU_UCODE_SEQ_COND_EOF_EN is undefined, INC_EOF_Z SHALL decode as INC and iZFlag SHALL be unused.

Structure
REQ-040 Shared package dzcpu_ucode_pkg SHALL hold the flow encodings (OP=0, INC=1, EOF=2, INC_EOF=3, INC_EOF_Z=4, JCB=5, CALL=6, RET=7) and the state encodings.
REQ-041 The return stack SHALL be sub-module dzcpu_ucode_stack (parameters ADDR_W and STACK_D; push, pop, clear, full and empty).

Verification
REQ-042 Flow test: LUT 0x31->1 and ROM 1..4 = INC, INC, OP, INC_EOF; accept 0x31 at cycle 0 -> uPC 1,2,3,4 on cycles 2-5, oPcInc on cycles 2, 3 and 5, oEof on cycle 5, oMopReady on cycle 6.
REQ-043 Conditional EOF (macro on): uop INC_EOF_Z with iZFlag=1 -> oEof and oPcInc, return to IDLE; with iZFlag=0 -> uPC advances and flow continues.
REQ-044 CB page: JCB, then accept 0x7C in CBWAIT -> oLutPage=1, uPC=CB LUT index 16 one cycle later.
REQ-045 Stack test (STACK_D=2): CALL 0x20 from uPC 5 -> uPC 0x20, RET -> uPC 6; a third nested CALL -> oStackErr=1 and oEof; RET on empty stack -> oStackErr=1.
REQ-046 Stall and reset: iStall=1 for 3 cycles mid-flow -> uPC held with no pulses; iReset mid-flow -> next cycle IDLE, uPC=0, oStackErr=0.
